// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 bus responder and its address-map helper.
package lcd_pkg;

  // Instruction opcodes; each is also the mask of its own highest set bit.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPCTL = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [7:0] SPACE = 8'h20;

  // Two-line DDRAM layout: 16 visible cells at the start of each line.
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         LINE_LEN   = 16;

  // Last address of each 40-cell line; stepping past it jumps to the other line.
  localparam logic [6:0] LINE1_WRAP = 7'h27;
  localparam logic [6:0] LINE2_WRAP = 7'h67;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_e;

endpackage

// File: rtl/lcd_ac_map.sv
// Address-counter helper: next AC value for increment/decrement with line wrap,
// and AC to mirror-buffer index mapping.
module lcd_ac_map
  import lcd_pkg::*;
(
  input  logic [6:0] ac_i,
  input  logic       inc_i,
  output logic [6:0] ac_next_o,
  output logic       visible_o,
  output logic [4:0] idx_o
);

  logic [6:0] off1;
  logic [6:0] off2;

  // Step the AC; decrement is the exact inverse of increment across both wraps.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    ac_next_o = ac_i;
    if (inc_i) begin
      if (ac_i == LINE1_WRAP)      ac_next_o = LINE2_BASE;
      else if (ac_i == LINE2_WRAP) ac_next_o = LINE1_BASE;
      else                         ac_next_o = ac_i + 7'd1;
    end else begin
      if (ac_i == LINE2_BASE)      ac_next_o = LINE1_WRAP;
      else if (ac_i == LINE1_BASE) ac_next_o = LINE2_WRAP;
      else                         ac_next_o = ac_i - 7'd1;
    end
  end

  // Map the visible window of each line onto buffer indices 0-15 and 16-31.
  always_comb begin
    off1      = ac_i - LINE1_BASE;
    off2      = ac_i - LINE2_BASE;
    visible_o = 1'b0;
    idx_o     = '0;
    if (off1 < 7'(LINE_LEN)) begin
      visible_o = 1'b1;
      idx_o     = 5'(off1);
    end else if (off2 < 7'(LINE_LEN)) begin
      visible_o = 1'b1;
      idx_o     = 5'(off2) + 5'(LINE_LEN);
    end
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Device side of the 8-bit HD44780 bus: decodes writes, keeps AC/busy state,
// answers status/data reads and mirrors the 32 visible characters.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYC  = 2000,
  parameter int CLEAR_CYC = 82000
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_E,
  inout  wire  [7:0] DATA_BUS,
  input  logic [4:0] iRD_IDX,
  output logic [7:0] oRD_CHAR,
  output logic       oWR_STB,
  output logic [4:0] oWR_IDX,
  output logic       oDISP_ON,
  output logic       oCURSOR_ON,
  output logic       oBLINK_ON,
  output logic       oTWO_LINE,
  output logic       oBUSY,
  output logic       oVIOL
);

  localparam int MAX_CYC = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYC);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC);
  localparam logic [4:0]       LAST_IDX   = 5'(2 * LINE_LEN - 1);

  // Pin synchronisers: {RS, RW, E, DATA}.
  logic [10:0] sync1_q, sync2_q;
  logic        e_prev_q;
  logic        rs_s, rw_s, e_s;
  logic [7:0]  data_s;
  logic        wr_acc, rd_step;

  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic             two_line_q, two_line_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  clr_state_e       state_q, state_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  logic             wr_stb_q, wr_stb_d;
  logic [4:0]       wr_idx_q, wr_idx_d;
  logic [7:0]       rd_char_q;
  logic [7:0]       buf_q [2*LINE_LEN];

  logic       buf_we;
  logic [4:0] buf_widx;
  logic [7:0] buf_wdata;
  logic [6:0] ac_next;
  logic       map_vis;
  logic [4:0] map_idx;
  logic       busy;
  logic [7:0] rd_data;

  assign {rs_s, rw_s, e_s, data_s} = sync2_q;
  assign wr_acc  = e_prev_q & ~e_s & ~rw_s;
  assign rd_step = e_prev_q & ~e_s & rw_s & rs_s;
  assign busy    = (cnt_q != '0);

  lcd_ac_map u_ac_map (
    .ac_i      (ac_q),
    .inc_i     (id_q),
    .ac_next_o (ac_next),
    .visible_o (map_vis),
    .idx_o     (map_idx)
  );

  // Two-stage synchroniser on the bus pins plus the E edge register.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    // NOTE: non-blocking assignments keep each stage sampling the previous stage's old value.
    if (!iRST_N) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      e_prev_q <= 1'b0;
    end else begin
      sync1_q  <= {LCD_RS, LCD_RW, LCD_E, DATA_BUS};
      sync2_q  <= sync1_q;
      e_prev_q <= e_s;
    end
  end

  // Decode accepted writes, step AC on data reads, and run the clear sweep.
  always_comb begin
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    cur_d      = cur_q;
    blink_d    = blink_q;
    two_line_d = two_line_q;
    viol_d     = viol_q;
    cnt_d      = busy ? cnt_q - CNT_W'(1) : cnt_q;
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    wr_stb_d   = 1'b0;
    wr_idx_d   = wr_idx_q;
    buf_we     = 1'b0;
    buf_widx   = map_idx;
    buf_wdata  = data_s;

    if (wr_acc) begin
      if (busy) begin
        viol_d = 1'b1;
      end else if (rs_s) begin
        cnt_d = BUSY_LOAD;
        if (map_vis) begin
          buf_we   = 1'b1;
          wr_stb_d = 1'b1;
          wr_idx_d = map_idx;
        end
        ac_d = ac_next;
      end else if (data_s != 8'h00) begin
        cnt_d = BUSY_LOAD;
        if (|(data_s & OP_DDRAM)) begin
          ac_d = data_s[6:0];
        end else if (|(data_s & OP_CGRAM)) begin
          // CGRAM is not mirrored.
        end else if (|(data_s & OP_FUNC)) begin
          two_line_d = data_s[3];
          if (!data_s[4]) viol_d = 1'b1;
        end else if (|(data_s & OP_SHIFT)) begin
          // Shifts do not change the mirrored contents.
        end else if (|(data_s & OP_DISPCTL)) begin
          {disp_d, cur_d, blink_d} = data_s[2:0];
        end else if (|(data_s & OP_ENTRY)) begin
          id_d = data_s[1];
        end else if (|(data_s & OP_HOME)) begin
          ac_d = LINE1_BASE;
        end else if (|(data_s & OP_CLEAR)) begin
          cnt_d     = CLEAR_LOAD;
          state_d   = CLR_SWEEP;
          clr_idx_d = '0;
        end
      end
    end else if (rd_step) begin
      ac_d = ac_next;
    end

    // The sweep always runs under the busy window, so it never collides with a data write.
    if (state_q == CLR_SWEEP) begin
      buf_we    = 1'b1;
      buf_widx  = clr_idx_q;
      buf_wdata = SPACE;
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == LAST_IDX) begin
        state_d = CLR_IDLE;
        ac_d    = LINE1_BASE;
        id_d    = 1'b1;
      end
    end
  end

  // Control and status state.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      ac_q       <= LINE1_BASE;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      cur_q      <= 1'b0;
      blink_q    <= 1'b0;
      two_line_q <= 1'b0;
      viol_q     <= 1'b0;
      cnt_q      <= '0;
      state_q    <= CLR_IDLE;
      clr_idx_q  <= '0;
      wr_stb_q   <= 1'b0;
      wr_idx_q   <= '0;
    end else begin
      ac_q       <= ac_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      cur_q      <= cur_d;
      blink_q    <= blink_d;
      two_line_q <= two_line_d;
      viol_q     <= viol_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      wr_stb_q   <= wr_stb_d;
      wr_idx_q   <= wr_idx_d;
    end
  end

  // Mirror buffer with a single write port.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    // NOTE: the buffer is reset because a reset must leave the mirror all spaces, even mid-clear.
    if (!iRST_N) begin
      for (int i = 0; i < 2 * LINE_LEN; i++) buf_q[i] <= SPACE;
    end else if (buf_we) begin
      buf_q[buf_widx] <= buf_wdata;
    end
  end

  // Host read port; a same-cycle write to the same index returns the old value.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) rd_char_q <= SPACE;
    else         rd_char_q <= buf_q[iRD_IDX];
  end

  // Bus read data: status or the character under the AC.
  always_comb begin
    if (rs_s) rd_data = map_vis ? buf_q[map_idx] : SPACE;
    else      rd_data = {busy, ac_q};
  end

  assign DATA_BUS   = (e_s && rw_s) ? rd_data : 8'hzz;
  assign oRD_CHAR   = rd_char_q;
  assign oWR_STB    = wr_stb_q;
  assign oWR_IDX    = wr_idx_q;
  assign oDISP_ON   = disp_q;
  assign oCURSOR_ON = cur_q;
  assign oBLINK_ON  = blink_q;
  assign oTWO_LINE  = two_line_q;
  assign oBUSY      = busy;
  assign oVIOL      = viol_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: drives the HD44780 bus like the
// LCD writer, keeps a reference model of AC and the mirror buffer, and scores
// oWR_STB events against a queue of expected writes.
`timescale 1ns/1ps
module tb_lcd_hd44780_responder;

  localparam int BUSY = 200;
  localparam int CLR  = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rs, rw, e;
  logic       host_oe;
  logic [7:0] host_data;
  logic [4:0] rd_idx;
  wire  [7:0] DATA_BUS;

  logic [7:0] rd_char;
  logic       wr_stb;
  logic [4:0] wr_idx;
  logic       disp_on, cursor_on, blink_on, two_line, busy_o, viol;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] ch;
  } wr_exp_t;
  wr_exp_t    exp_q[$];
  logic [7:0] exp_buf [32];
  logic [6:0] m_ac;
  logic       m_id;

  always #10 clk = ~clk;

  assign DATA_BUS = host_oe ? host_data : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (DATA_BUS[g]);
  end

  lcd_hd44780_responder #(.BUSY_CYC(BUSY), .CLEAR_CYC(CLR)) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .LCD_RS     (rs),
    .LCD_RW     (rw),
    .LCD_E      (e),
    .DATA_BUS   (DATA_BUS),
    .iRD_IDX    (rd_idx),
    .oRD_CHAR   (rd_char),
    .oWR_STB    (wr_stb),
    .oWR_IDX    (wr_idx),
    .oDISP_ON   (disp_on),
    .oCURSOR_ON (cursor_on),
    .oBLINK_ON  (blink_on),
    .oTWO_LINE  (two_line),
    .oBUSY      (busy_o),
    .oVIOL      (viol)
  );

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_stb === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_stb_unexpected: got strobe at idx %0d, none expected", wr_idx);
      end else begin
        wr_exp_t x;
        x = exp_q.pop_front();
        if (wr_idx !== x.idx) begin
          n_fail++;
          $display("FAIL wr_stb_idx: got %0d, expected %0d", wr_idx, x.idx);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
    if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
  endfunction

  function automatic logic m_vis(input logic [6:0] a);
    return (a <= 7'h0F) || (a >= 7'h40 && a <= 7'h4F);
  endfunction

  function automatic logic [4:0] m_idx(input logic [6:0] a);
    return (a <= 7'h0F) ? {1'b0, a[3:0]} : {1'b1, a[3:0]};
  endfunction

  // ---------------- bus primitives ----------------
  task automatic lcd_write(input logic r, input logic [7:0] d);
    host_oe = 1'b1; rs = r; rw = 1'b0; host_data = d;
    @(negedge clk); e = 1'b1;
    repeat (4) @(negedge clk);
    e = 1'b0;
    repeat (4) @(negedge clk);
    host_oe = 1'b0;
  endtask

  task automatic lcd_read(input logic r, output logic [7:0] v);
    host_oe = 1'b0; rs = r; rw = 1'b1;
    @(negedge clk); e = 1'b1;
    repeat (4) @(negedge clk);
    v = DATA_BUS;
    e = 1'b0;
    repeat (4) @(negedge clk);
    rw = 1'b0;
  endtask

  task automatic wait_ready(output logic [7:0] st);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      lcd_read(1'b0, st);
      if (st[7] === 1'b0) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL busy_timeout: status still %h after 100 polls", st);
    end
  endtask

  task automatic host_read(input int idx, output logic [7:0] v);
    rd_idx = 5'(idx);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic instr(input logic [7:0] d);
    logic [7:0] st;
    wait_ready(st);
    lcd_write(1'b0, d);
    if (d[7])      m_ac = d[6:0];
    else if (d[6] || d[5] || d[4] || d[3]) begin end
    else if (d[2]) m_id = d[1];
    else if (d[1]) m_ac = 7'h00;
    else if (d[0]) begin
      m_ac = 7'h00; m_id = 1'b1;
      for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    end
  endtask

  task automatic data_wr(input logic [7:0] d);
    logic [7:0] st;
    wait_ready(st);
    if (m_vis(m_ac)) begin
      exp_q.push_back('{idx: m_idx(m_ac), ch: d});
      exp_buf[m_idx(m_ac)] = d;
    end
    lcd_write(1'b1, d);
    m_ac = m_step(m_ac, m_id);
  endtask

  task automatic data_rd(output logic [7:0] v);
    lcd_read(1'b1, v);
    m_ac = m_step(m_ac, m_id);
  endtask

  task automatic check_buffer(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      host_read(i, v);
      n_checks++;
      if (v !== exp_buf[i]) begin
        n_fail++;
        $display("FAIL %s idx %0d: got %h, expected %h", tag, i, v, exp_buf[i]);
      end
    end
  endtask

  task automatic expect_status(input string tag, input logic [7:0] exp);
    logic [7:0] st;
    wait_ready(st);
    n_checks++;
    if (st !== exp) begin
      n_fail++;
      $display("FAIL %s: status %h, expected %h", tag, st, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    n_checks++;
    if ({busy_o, viol, wr_stb} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/viol/stb %b, expected 000", {busy_o, viol, wr_stb});
    end
    n_checks++;
    if ({two_line, disp_on, cursor_on, blink_on} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: N/D/C/B %b, expected 0000", {two_line, disp_on, cursor_on, blink_on});
    end
    n_checks++;
    if (rd_char !== 8'h20) begin
      n_fail++;
      $display("FAIL reset_rd_char: got %h, expected 20", rd_char);
    end
    n_checks++;
    if (DATA_BUS !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_bus_released: bus %h, expected pulled-up ff", DATA_BUS);
    end
    expect_status("reset_status", 8'h00);
  endtask

  task automatic test_init;
    logic [7:0] seq [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h0C, 8'h06};
    foreach (seq[i]) instr(seq[i]);
    expect_status("init_status", 8'h00);
    n_checks++;
    if ({two_line, disp_on, cursor_on, blink_on, viol} !== 5'b11000) begin
      n_fail++;
      $display("FAIL init_ctl: N/D/C/B/viol %b, expected 11000",
               {two_line, disp_on, cursor_on, blink_on, viol});
    end
    check_buffer("init_buffer");
  endtask

  task automatic test_data_write;
    logic [7:0] v;
    data_wr(8'h41);
    data_wr(8'h42);
    host_read(1, v);
    n_checks++;
    if (v !== 8'h42) begin
      n_fail++;
      $display("FAIL host_read_idx1: got %h, expected 42", v);
    end
    expect_status("status_after_AB", 8'h02);
    instr(8'h80);
    data_rd(v);
    n_checks++;
    if (v !== 8'h41) begin
      n_fail++;
      $display("FAIL data_read_idx0: got %h, expected 41", v);
    end
    expect_status("status_after_data_read", 8'h01);
  endtask

  task automatic test_line_boundary;
    logic [7:0] v;
    instr(8'h8F);
    data_wr(8'h5A);
    data_wr(8'h5B);
    expect_status("status_after_line_end", 8'h11);
    host_read(15, v);
    n_checks++;
    if (v !== 8'h5A) begin
      n_fail++;
      $display("FAIL idx15: got %h, expected 5a", v);
    end
    instr(8'hA7);
    data_wr(8'h77);
    expect_status("inc_wrap_27_to_40", 8'h40);
    instr(8'h04);
    instr(8'hC0);
    data_wr(8'h6B);
    expect_status("dec_wrap_40_to_27", 8'h27);
    host_read(16, v);
    n_checks++;
    if (v !== 8'h6B) begin
      n_fail++;
      $display("FAIL idx16: got %h, expected 6b", v);
    end
    data_rd(v);
    n_checks++;
    if (v !== 8'h20) begin
      n_fail++;
      $display("FAIL data_read_invisible: got %h, expected 20", v);
    end
    expect_status("dec_after_read", 8'h26);
    check_buffer("boundary_buffer");
  endtask

  task automatic test_busy_violation;
    int cnt;
    instr(8'h06);
    instr(8'h85);
    data_wr(8'h61);
    repeat (90) @(negedge clk);
    lcd_write(1'b1, 8'h62);
    n_checks++;
    if (viol !== 1'b1) begin
      n_fail++;
      $display("FAIL viol_set: got %b, expected 1", viol);
    end
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 2 * BUSY) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt > 150) begin
      n_fail++;
      $display("FAIL busy_not_reloaded: busy lasted %0d more cycles, expected at most 150", cnt);
    end
    expect_status("ac_after_ignored_write", 8'h06);
    instr(8'h80);
    n_checks++;
    if (viol !== 1'b1) begin
      n_fail++;
      $display("FAIL viol_sticky: got %b, expected 1", viol);
    end
    check_buffer("viol_buffer");
  endtask

  task automatic test_clear_reset;
    logic [7:0] st;
    instr(8'h80);
    for (int i = 0; i < 16; i++) data_wr(8'h30 + 8'(i));
    instr(8'hC0);
    for (int i = 0; i < 16; i++) data_wr(8'h50 + 8'(i));
    check_buffer("full_buffer");
    wait_ready(st);
    rd_idx = 5'd0;
    host_oe = 1'b1; rs = 1'b0; rw = 1'b0; host_data = 8'h01;
    @(negedge clk); e = 1'b1;
    repeat (4) @(negedge clk);
    e = 1'b0;
    repeat (11) @(negedge clk);
    n_checks++;
    if (rd_char !== 8'h20) begin
      n_fail++;
      $display("FAIL partial_clear_idx0: got %h, expected 20", rd_char);
    end
    rd_idx = 5'd31;
    @(negedge clk);
    n_checks++;
    if (rd_char !== 8'h5F || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_clear_idx31: char %h busy %b, expected 5f busy 1", rd_char, busy_o);
    end
    rst_n = 1'b0;
    host_oe = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ac = 7'h00; m_id = 1'b1;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    n_checks++;
    if ({busy_o, viol} !== 2'b00 || DATA_BUS !== 8'hFF) begin
      n_fail++;
      $display("FAIL after_reset: busy/viol %b bus %h, expected 00 and ff", {busy_o, viol}, DATA_BUS);
    end
    expect_status("status_after_reset", 8'h00);
    check_buffer("buffer_after_reset");
  endtask

  initial begin
    rst_n = 1'b0; rs = 1'b0; rw = 1'b0; e = 1'b0;
    host_oe = 1'b0; host_data = 8'h00; rd_idx = 5'd0;
    m_ac = 7'h00; m_id = 1'b1;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_init();
    test_data_write();
    test_line_boundary();
    test_busy_violation();
    test_clear_reset();

    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_wr_stb: %0d expected writes never strobed", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
